// File: rtl/lock_sequencer_if.sv
// Keypad-side and actuator-side signals of the combination lock controller.
// master: the block feeding keypad events and reading lock status.
// slave: the lock_sequencer itself.
interface lock_sequencer_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       prog_req;
  logic       unlock;
  logic       fail_pulse;
  logic       locked_out;
  logic [3:0] tries_left;
  logic [2:0] digit_cnt;
  logic [2:0] state_o;

  modport master (
    output digit_valid, digit, clear, prog_req,
    input  unlock, fail_pulse, locked_out, tries_left, digit_cnt, state_o
  );

  modport slave (
    input  digit_valid, digit, clear, prog_req,
    output unlock, fail_pulse, locked_out, tries_left, digit_cnt, state_o
  );
endinterface

// File: rtl/lock_sequencer.sv
// Combination lock controller: collects 4 keypad digits, compares with the key, drives unlock/lockout.
// Latency: 4th digit accepted in cycle N -> unlock or fail_pulse in cycle N+2; all outputs registered.
// No backpressure: digits outside IDLE/ENTRY/PROG are dropped. Optional key reprogramming: LOCK_REPROGRAM_EN.
module lock_sequencer #(
  parameter logic [15:0] RESET_KEY      = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          OPEN_CYCLES    = 500,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input logic             clk,
  input logic             rst,
  lock_sequencer_if.slave bus
);

  // One timer serves both OPEN and LOCKOUT, sized for the longer of the two.
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_PROG    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     entry_q, entry_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      tries_q, tries_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     key_w;
  logic [15:0]     entry_shift;

  assign entry_shift = {entry_q[11:0], bus.digit};

`ifdef LOCK_REPROGRAM_EN
  logic [15:0] key_q, key_d;
  assign key_w = key_q;
`else
  assign key_w = RESET_KEY;
`endif

  // Every output is a decode of, or a copy of, a register.
  assign bus.unlock     = (state_q == S_OPEN);
  assign bus.fail_pulse = (state_q == S_FAIL);
  assign bus.locked_out = (state_q == S_LOCKOUT);
  assign bus.tries_left = tries_q;
  assign bus.digit_cnt  = cnt_q;
  assign bus.state_o    = state_q;

  // State, entry, counters and key registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      tries_q <= TRIES_INIT;
      timer_q <= '0;
`ifdef LOCK_REPROGRAM_EN
      key_q   <= RESET_KEY;
`endif
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
`ifdef LOCK_REPROGRAM_EN
      key_q   <= key_d;
`endif
    end
  end

  // Next-state and datapath updates for the lock sequence.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    timer_d = timer_q;
`ifdef LOCK_REPROGRAM_EN
    key_d   = key_q;
`endif
    case (state_q)
      S_IDLE: begin
        // clear has no meaning before the first digit, so the digit is taken.
        if (bus.digit_valid) begin
          entry_d = entry_shift;
          cnt_d   = 3'd1;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (bus.clear) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (bus.digit_valid) begin
          entry_d = entry_shift;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        // entry_q is stable here, so the compare sees only registered operands.
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
        if (entry_q == key_w) begin
          tries_d = TRIES_INIT;
          state_d = S_OPEN;
        end else begin
          tries_d = (tries_q != 4'd0) ? tries_q - 4'd1 : 4'd0;
          state_d = S_FAIL;
        end
      end
      S_OPEN: begin
`ifdef LOCK_REPROGRAM_EN
        if (bus.prog_req) begin
          timer_d = '0;
          state_d = S_PROG;
        end else
`endif
        if (timer_q == OPEN_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FAIL: begin
        timer_d = '0;
        state_d = (tries_q == 4'd0) ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          timer_d = '0;
          tries_d = TRIES_INIT;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef LOCK_REPROGRAM_EN
      S_PROG: begin
        if (bus.clear) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (bus.digit_valid) begin
          entry_d = entry_shift;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            key_d   = entry_shift;
            entry_d = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
`endif
      default: begin
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed test-plan sequences followed by random keypad traffic.
// A countdown-based reference model predicts every output each cycle.
// Build with +define+LOCK_REPROGRAM_EN to exercise key reprogramming.
module tb_lock_sequencer;
  localparam int MAX_T  = 3;
  localparam int OPEN_C = 8;
  localparam int LOCK_C = 16;

  logic clk = 1'b0;
  logic rst;
  lock_sequencer_if bus();

  lock_sequencer #(
    .RESET_KEY      (16'h1234),
    .MAX_TRIES      (MAX_T),
    .OPEN_CYCLES    (OPEN_C),
    .LOCKOUT_CYCLES (LOCK_C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the lock looks like after each edge.
  int m_dig[$];     // digits held in the current entry / reprogram attempt
  bit m_check;      // comparison cycle pending
  bit m_fail;       // wrong-code strobe cycle
  bit m_prog;       // reprogram mode
  int m_open_left;  // unlock cycles still to show
  int m_lock_left;  // lockout cycles still to show
  int m_tries;
  int m_key;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int packed_entry();
    int v = 0;
    foreach (m_dig[i]) v = (v << 4) | m_dig[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_dig.delete();
    m_check = 0; m_fail = 0; m_prog = 0;
    m_open_left = 0; m_lock_left = 0;
    m_tries = MAX_T;
    m_key = 16'h1234;
  endfunction

  function automatic void model_step(bit r, bit dv, int d, bit c, bit p);
    if (r) begin
      model_reset();
    end else if (m_check) begin
      m_check = 0;
      if (packed_entry() == m_key) begin
        m_open_left = OPEN_C;
        m_tries = MAX_T;
      end else begin
        m_fail = 1;
        if (m_tries > 0) m_tries--;
      end
      m_dig.delete();
    end else if (m_fail) begin
      m_fail = 0;
      if (m_tries == 0) m_lock_left = LOCK_C;
    end else if (m_open_left > 0) begin
`ifdef LOCK_REPROGRAM_EN
      if (p) begin
        m_open_left = 0;
        m_prog = 1;
      end else
`endif
        m_open_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_tries = MAX_T;
    end else if (c && (m_dig.size() > 0 || m_prog)) begin
      m_dig.delete();
      m_prog = 0;
    end else if (dv) begin
      m_dig.push_back(d);
      if (m_dig.size() == 4) begin
        if (m_prog) begin
          m_key = packed_entry();
          m_dig.delete();
          m_prog = 0;
        end else begin
          m_check = 1;
        end
      end
    end
  endfunction

  task automatic compare_outputs();
    int exp_state;
    if (m_check)              exp_state = 2;
    else if (m_fail)          exp_state = 4;
    else if (m_open_left > 0) exp_state = 3;
    else if (m_lock_left > 0) exp_state = 5;
    else if (m_prog)          exp_state = 6;
    else if (m_dig.size() > 0) exp_state = 1;
    else                      exp_state = 0;
    chk("state",      32'(bus.state_o),    32'(exp_state));
    chk("unlock",     32'(bus.unlock),     32'(m_open_left > 0));
    chk("fail_pulse", 32'(bus.fail_pulse), 32'(m_fail));
    chk("locked_out", 32'(bus.locked_out), 32'(m_lock_left > 0));
    chk("tries_left", 32'(bus.tries_left), 32'(m_tries));
    chk("digit_cnt",  32'(bus.digit_cnt),  32'(m_dig.size()));
  endtask

  // One clock: check what the last edge produced, then apply this cycle's inputs.
  task automatic step(input bit r, input bit dv, input int d, input bit c, input bit p);
    @(negedge clk);
    compare_outputs();
    rst             = r;
    bus.digit_valid = dv;
    bus.digit       = 4'(d);
    bus.clear       = c;
    bus.prog_req    = p;
    model_step(r, dv, d, c, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic enter(input int code);
    for (int i = 3; i >= 0; i--) step(0, 1, (code >> (4 * i)) & 15, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.digit_valid = 1'b0;
    bus.digit = 4'd0;
    bus.clear = 1'b0;
    bus.prog_req = 1'b0;
    model_reset();
    step(1, 0, 0, 0, 0);

    // Unlock with the reset key, then run out the open window.
    enter(16'h1234);
    idle(12);

    // Three wrong codes into lockout; right code during lockout is ignored.
    for (int k = 0; k < 3; k++) begin
      enter(16'h0000);
      idle(3);
    end
    enter(16'h1234);
    idle(20);

    // Abandon a partial entry, then the right code.
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    enter(16'h1234);
    idle(12);

    // Clear and digit together after two digits.
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 1, 3, 1, 0);
    idle(2);

    // Digit arriving while the comparison happens is dropped.
    enter(16'h1234);
    step(0, 1, 9, 0, 0);
    idle(3);

    // Reset in the middle of the open window.
    step(1, 0, 0, 0, 0);
    idle(2);
    enter(16'h1234);
    idle(3);
    step(1, 0, 0, 0, 0);
    idle(2);

    // Reprogram to ABCD, old code fails, new code opens.
    enter(16'h1234);
    idle(3);
    step(0, 0, 0, 0, 1);
    enter(16'hABCD);
    idle(2);
    enter(16'h1234);
    idle(3);
    enter(16'hABCD);
    idle(12);
    // Reset restores the factory key.
    step(1, 0, 0, 0, 0);
    idle(1);
    enter(16'h1234);
    idle(3);
    // Clear during reprogramming keeps the key.
    step(0, 0, 0, 0, 1);
    step(0, 1, 5, 0, 0);
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(2);
    enter(16'h1234);
    idle(12);

    // Random traffic, biased toward digits of the current key.
    for (int i = 0; i < 4000; i++) begin
      bit r, dv, c, p;
      int d, pos;
      r  = ($urandom_range(0, 299) == 0);
      dv = ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 24) == 0);
      p  = ($urandom_range(0, 7) == 0);
      pos = m_dig.size() % 4;
      if ($urandom_range(0, 9) < 7)
        d = (m_key >> (4 * (3 - pos))) & 15;
      else
        d = $urandom_range(0, 15);
      step(r, dv, d, c, p);
    end
    @(negedge clk);
    compare_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
